// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared widths, fetch FSM encoding and PC helpers for ifetch_unit
package ifetch_unit_pkg;

   localparam int REGWIDTH = 32;

   localparam logic [REGWIDTH-1:0] PC_STEP          = 32'd4;
   localparam logic [REGWIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2,
      HALT = 2'd3
   } ifetch_state_t;

   // Sequential successor; wraps modulo 2^32 with no carry out.
   function automatic logic [REGWIDTH-1:0] next_pc(input logic [REGWIDTH-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/ifetch_out_buf.sv
// rtl/ifetch_out_buf.sv - single-entry valid/ready holding register between fetch and decode
module ifetch_out_buf
   import ifetch_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [REGWIDTH-1:0] load_inst,
   input  logic [REGWIDTH-1:0] load_pc,
   input  logic                consume,
   input  logic                flush,
   output logic                valid,
   output logic [REGWIDTH-1:0] inst,
   output logic [REGWIDTH-1:0] pc
);

   // Flush wins over load so a response racing a redirect never reaches decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         inst  <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         inst  <= load_inst;
         pc    <= load_pc;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - RV32 fetch stage: owns PC, single outstanding imem request, redirect flush
// Optional IFETCH_MISALIGN_EN: misaligned redirect target sets sticky fetch_fault and halts fetch.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [REGWIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [REGWIDTH-1:0] imem_addr,
   input  logic                imem_rvalid,
   input  logic [REGWIDTH-1:0] imem_rdata,
   input  logic                redirect_valid,
   input  logic [REGWIDTH-1:0] redirect_pc,
   output logic                inst_valid,
   output logic [REGWIDTH-1:0] inst,
   output logic [REGWIDTH-1:0] inst_pc,
   input  logic                inst_ready,
   output logic                fetch_fault
);

   ifetch_state_t       state, state_nx;
   logic [REGWIDTH-1:0] pc, pc_nx;
   logic [REGWIDTH-1:0] target;
   logic                misalign;
   logic                fault_q, fault_set;
   logic                req;
   logic                buf_load, buf_flush, buf_consume;

`ifdef IFETCH_MISALIGN_EN
   assign target   = redirect_pc;
   assign misalign = (redirect_pc[1:0] != 2'b00);
`else
   assign target   = redirect_pc & ~32'h0000_0003;
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      req       = 1'b0;
      buf_load  = 1'b0;
      buf_flush = 1'b0;
      fault_set = 1'b0;
      if (redirect_valid && (state != HALT)) begin
         buf_flush = 1'b1;
         if (misalign) begin
            fault_set = 1'b1;
            state_nx  = HALT;
         end else begin
            pc_nx = target;
            // A response landing with the redirect drains the outstanding request.
            if ((state == WAIT) || (state == DROP))
               state_nx = imem_rvalid ? IDLE : DROP;
         end
      end else begin
         case (state)
            IDLE: begin
               if (!inst_valid || inst_ready) begin
                  req      = 1'b1;
                  state_nx = WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  buf_load = 1'b1;
                  pc_nx    = next_pc(pc);
                  state_nx = IDLE;
               end
            end
            DROP: begin
               if (imem_rvalid)
                  state_nx = IDLE;
            end
            default: begin
               state_nx = HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (fault_set)
            fault_q <= 1'b1;
      end
   end

   // Gate with reset so the request pulse is low while rst is held.
   assign imem_req    = req & rst;
   assign imem_addr   = pc;
   assign fetch_fault = fault_q;
   assign buf_consume = inst_valid & inst_ready;

   ifetch_out_buf u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_inst (imem_rdata),
      .load_pc   (pc),
      .consume   (buf_consume),
      .flush     (buf_flush),
      .valid     (inst_valid),
      .inst      (inst),
      .pc        (inst_pc)
   );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with memory responder and stream model
module tb_ifetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_req, imem_rvalid, redirect_valid, inst_valid, inst_ready, fetch_fault;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

   logic        rst_w, w_req, w_rvalid, w_valid, w_fault, w_redir, w_ready;
   logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_redir_pc;

   ifetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .fetch_fault(fetch_fault)
   );

   ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
      .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
      .inst_ready(w_ready), .fetch_fault(w_fault)
   );

   int          checks = 0;
   int          errors = 0;

   // Memory responder model: one pending request, fixed latency chosen at request time.
   bit          mem_pend = 0;
   int          mem_cnt = 0;
   int          mem_lat = 1;
   bit          mem_nop = 1;
   bit          mem_overlap = 0;
   logic [31:0] mem_a = '0;

   logic        s_req, s_valid, s_fault;
   logic [31:0] s_addr, s_inst, s_pc;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      if (mem_nop) return 32'h0000_0013;
      return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic clk_step();
      @(negedge clk);
      imem_rvalid = mem_pend && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? word_of(mem_a) : $urandom;
      #1;
      s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
      s_inst = inst; s_pc = inst_pc; s_fault = fetch_fault;
      @(posedge clk);
      if (imem_rvalid) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (s_req && rst) begin
         if (mem_pend) mem_overlap = 1;
         mem_pend = 1; mem_cnt = mem_lat - 1; mem_a = s_addr;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      mem_lat = 1; mem_nop = 1;
      repeat (3) clk_step();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", s_req); end
      checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", s_addr); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", s_valid); end
      checks++; if (s_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", s_inst); end
      checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", s_pc); end
      checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", s_fault); end
      rst = 1'b1;
   endtask

   task automatic test_sequence();
      for (int i = 0; i < 6; i++) begin
         clk_step();
         checks++; if (s_req !== (i % 2 == 0)) begin errors++; $display("FAIL seq_req[%0d] got %b", i, s_req); end
         if (i % 2 == 0) begin
            checks++; if (s_addr !== 32'(4 * (i / 2))) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, s_addr, 4 * (i / 2)); end
         end
         checks++; if (s_valid !== (i % 2 == 0 && i > 0)) begin errors++; $display("FAIL seq_valid[%0d] got %b", i, s_valid); end
         if (i % 2 == 0 && i > 0) begin
            checks++; if (s_pc !== 32'(4 * (i / 2 - 1))) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, s_pc, 4 * (i / 2 - 1)); end
            checks++; if (s_inst !== 32'h13) begin errors++; $display("FAIL seq_inst[%0d] got %h exp 13", i, s_inst); end
         end
      end
   endtask

   task automatic test_stall();
      inst_ready = 1'b0;
      mem_nop = 0;
      for (int i = 0; i < 5; i++) begin
         clk_step();
         checks++; if (s_valid !== 1'b1 || s_pc !== 32'h8 || s_inst !== 32'h13)
            begin errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h inst=%h exp v=1 pc=8 inst=13", i, s_valid, s_pc, s_inst); end
         checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, s_req); end
      end
      inst_ready = 1'b1;
      clk_step();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'hC || s_valid !== 1'b1)
         begin errors++; $display("FAIL stall_release got req=%b addr=%h v=%b exp 1 c 1", s_req, s_addr, s_valid); end
   endtask

   task automatic test_redirect_wait();
      int n;
      bit found;
      clk_step();
      mem_lat = 4;
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin clk_step(); found = s_req; end
      checks++; if (!found) begin errors++; $display("FAIL rdw_first_req got timeout exp req"); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      clk_step();
      redirect_valid = 1'b0;
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rdw_req_on_redirect got %b exp 0", s_req); end
      found = 0; n = 0;
      while (!found && n < 12) begin
         clk_step(); n++;
         checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rdw_stale_valid[%0d] got %b exp 0 inst=%h", n, s_valid, s_inst); end
         found = s_req;
      end
      mem_lat = 1;
      checks++; if (!found || s_addr !== 32'h100) begin errors++; $display("FAIL rdw_next_addr got found=%b addr=%h exp 100", found, s_addr); end
      checks++; if (n !== 4) begin errors++; $display("FAIL rdw_req_cycle got %0d exp 4", n); end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin clk_step(); found = s_valid; end
      checks++; if (!found || s_pc !== 32'h100 || s_inst !== word_of(32'h100))
         begin errors++; $display("FAIL rdw_deliver got v=%b pc=%h inst=%h exp pc=100 inst=%h", found, s_pc, s_inst, word_of(32'h100)); end
   endtask

   task automatic test_redirect_same();
      bit found = 0;
      mem_lat = 1;
      for (int i = 0; i < 8 && !found; i++) begin clk_step(); found = s_req; end
      checks++; if (!found) begin errors++; $display("FAIL rds_first_req got timeout exp req"); end
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      clk_step();
      redirect_valid = 1'b0;
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rds_req_on_redirect got %b exp 0", s_req); end
      clk_step();
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rds_dropped_valid got %b exp 0", s_valid); end
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL rds_next_req got req=%b addr=%h exp 1 200", s_req, s_addr); end
      clk_step();
      clk_step();
      checks++; if (s_valid !== 1'b1 || s_pc !== 32'h200 || s_inst !== word_of(32'h200))
         begin errors++; $display("FAIL rds_deliver got v=%b pc=%h inst=%h exp pc=200", s_valid, s_pc, s_inst); end
   endtask

   // Stream model: requests walk m_pc by 4, decode sees d_pc by 4, redirects reset both.
   task automatic test_random();
      logic [31:0] m_pc, d_pc, h_inst, h_pc;
      bit          prev_redir = 0, prev_hold = 0;
      int          accepts = 0;
      m_pc = '0; d_pc = '0; h_inst = '0; h_pc = '0;
      mem_overlap = 0;
      for (int i = 0; i < 600; i++) begin
         redirect_valid = (i == 0) || ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         inst_ready     = ($urandom_range(0, 3) != 0);
         mem_lat        = $urandom_range(1, 4);
         clk_step();
         if (s_req) begin
            checks++; if (redirect_valid) begin errors++; $display("FAIL rnd_req_during_redirect[%0d] got req=1 exp 0", i); end
            checks++; if (s_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, s_addr, m_pc); end
            m_pc = m_pc + 32'd4;
         end
         if (prev_redir) begin
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush[%0d] got %b exp 0", i, s_valid); end
         end else if (prev_hold) begin
            checks++; if (s_valid !== 1'b1 || s_inst !== h_inst || s_pc !== h_pc)
               begin errors++; $display("FAIL rnd_hold[%0d] got v=%b pc=%h inst=%h exp pc=%h inst=%h", i, s_valid, s_pc, s_inst, h_pc, h_inst); end
         end
         if (s_valid && inst_ready && !redirect_valid) begin
            checks++; if (s_pc !== d_pc || s_inst !== word_of(d_pc))
               begin errors++; $display("FAIL rnd_deliver[%0d] got pc=%h inst=%h exp pc=%h inst=%h", i, s_pc, s_inst, d_pc, word_of(d_pc)); end
            d_pc = d_pc + 32'd4;
            accepts++;
         end
         if (redirect_valid) begin m_pc = redirect_pc; d_pc = redirect_pc; end
         prev_redir = redirect_valid;
         prev_hold  = s_valid && !inst_ready;
         h_inst = s_inst; h_pc = s_pc;
      end
      redirect_valid = 1'b0; inst_ready = 1'b1;
      checks++; if (mem_overlap) begin errors++; $display("FAIL rnd_outstanding got overlap=1 exp 0"); end
      checks++; if (accepts < 50) begin errors++; $display("FAIL rnd_progress got %0d exp >=50", accepts); end
   endtask

   task automatic test_wrap();
      rst_w = 1'b1;
      @(negedge clk); #1;
      checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got req=%b addr=%h exp 1 fffffffc", w_req, w_addr); end
      @(posedge clk); #1;
      w_rvalid = 1'b1; w_rdata = 32'h0000_0073;
      @(negedge clk); #1;
      checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL wrap_wait_req got %b exp 0", w_req); end
      @(posedge clk); #1;
      w_rvalid = 1'b0;
      @(negedge clk); #1;
      checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_second got req=%b addr=%h exp 1 0", w_req, w_addr); end
      checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_inst !== 32'h73)
         begin errors++; $display("FAIL wrap_deliver got v=%b pc=%h inst=%h exp 1 fffffffc 73", w_valid, w_pc, w_inst); end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign();
      bit found = 0;
      inst_ready = 1'b1; mem_lat = 1;
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      clk_step();
      redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_EN
      for (int i = 0; i < 8; i++) begin
         redirect_valid = (i == 3); redirect_pc = 32'h300;
         clk_step();
         checks++; if (s_fault !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0)
            begin errors++; $display("FAIL halt[%0d] got fault=%b req=%b v=%b exp 1 0 0", i, s_fault, s_req, s_valid); end
      end
      redirect_valid = 1'b0;
      rst = 1'b0; #1;
      checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL halt_reset_fault got %b exp 0", fetch_fault); end
      clk_step();
      rst = 1'b1;
      clk_step();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL halt_restart got req=%b addr=%h exp 1 0", s_req, s_addr); end
`else
      for (int i = 0; i < 10 && !found; i++) begin
         clk_step(); found = s_req;
         checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL align_fault[%0d] got %b exp 0", i, s_fault); end
      end
      checks++; if (!found || s_addr !== 32'h100) begin errors++; $display("FAIL align_addr got found=%b addr=%h exp 100", found, s_addr); end
`endif
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      mem_lat = 3; inst_ready = 1'b1;
      for (int i = 0; i < 10 && !found; i++) begin clk_step(); found = s_req; end
      checks++; if (!found) begin errors++; $display("FAIL rmid_req got timeout exp req"); end
      rst = 1'b0; #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_req_addr got req=%b addr=%h exp 0 0", imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || fetch_fault !== 1'b0)
         begin errors++; $display("FAIL rmid_outputs got v=%b inst=%h pc=%h f=%b exp all 0", inst_valid, inst, inst_pc, fetch_fault); end
      mem_lat = 1;
      repeat (4) clk_step();
      rst = 1'b1;
      clk_step();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL rmid_first got req=%b addr=%h exp 1 0", s_req, s_addr); end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin clk_step(); found = s_valid; end
      checks++; if (!found || s_pc !== 32'h0 || s_inst !== word_of(32'h0))
         begin errors++; $display("FAIL rmid_deliver got v=%b pc=%h inst=%h exp pc=0 inst=%h", found, s_pc, s_inst, word_of(32'h0)); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; rst_w = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      w_rvalid = 1'b0; w_rdata = '0; w_redir = 1'b0; w_redir_pc = '0; w_ready = 1'b1;
      test_reset();
      test_sequence();
      test_stall();
      test_redirect_wait();
      test_redirect_same();
      test_random();
      test_wrap();
      test_misalign();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
